morse_decoder: RTL and testbench

- Receive-side counterpart of the team's Morse keying logic.
- Samples a keyed on/off line `w` once per `clk`; one sample equals one Morse time unit.
- Classifies marks as dot or dash and detects letter boundaries from space length.
- Emits the assembled letter as a registered symbol pattern with a one-cycle valid strobe, plus a dedicated letter-B match flag.

---
 rtl/morse_decoder.sv | 189 ++++++++++++++++++
 tb/tb_morse_decoder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/morse_decoder.sv
// Morse receive decoder: samples w once per clk, assembles dot/dash letters.
// Optional ASCII lookup enabled by defining MORSE_ASCII_EN.
module morse_decoder #(
    parameter int DOT_MAX    = 2,
    parameter int DASH_MAX   = 6,
    parameter int LETTER_GAP = 3,
    parameter int MAX_SYMS   = 6,
    parameter int CNT_W      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                w,
    output logic [MAX_SYMS-1:0] code,
    output logic [2:0]          len,
    output logic                valid,
    output logic                is_b,
    output logic                err,
    output logic [7:0]          ascii
);

    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

    localparam logic [CNT_W-1:0] RUN_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DOT_LIM  = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] DASH_LIM = CNT_W'(DASH_MAX);
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(LETTER_GAP);
    localparam logic [2:0]       SYM_LIM  = 3'(MAX_SYMS);
    localparam logic [MAX_SYMS-1:0] B_CODE = MAX_SYMS'(1);

    state_t              state;
    logic [CNT_W-1:0]    run;
    logic [2:0]          cnt;
    logic [MAX_SYMS-1:0] sreg;
    logic                flag;

    logic [CNT_W-1:0]    run_inc;
    logic [MAX_SYMS-1:0] sreg_nx;
    logic [2:0]          cnt_nx;
    logic                flag_nx;
    logic                do_emit;
    logic [MAX_SYMS-1:0] em_sreg;
    logic [2:0]          em_cnt;
    logic                em_flag;

`ifdef MORSE_ASCII_EN
    // Letters A-Z keyed on {symbol count, pattern}; bit 0 is the first symbol.
    function automatic logic [7:0] lookup(input logic [8:0] key);
        case (key)
            {3'd2, 6'b000010}: return 8'h41;
            {3'd4, 6'b000001}: return 8'h42;
            {3'd4, 6'b000101}: return 8'h43;
            {3'd3, 6'b000001}: return 8'h44;
            {3'd1, 6'b000000}: return 8'h45;
            {3'd4, 6'b000100}: return 8'h46;
            {3'd3, 6'b000011}: return 8'h47;
            {3'd4, 6'b000000}: return 8'h48;
            {3'd2, 6'b000000}: return 8'h49;
            {3'd4, 6'b001110}: return 8'h4A;
            {3'd3, 6'b000101}: return 8'h4B;
            {3'd4, 6'b000010}: return 8'h4C;
            {3'd2, 6'b000011}: return 8'h4D;
            {3'd2, 6'b000001}: return 8'h4E;
            {3'd3, 6'b000111}: return 8'h4F;
            {3'd4, 6'b000110}: return 8'h50;
            {3'd4, 6'b001011}: return 8'h51;
            {3'd3, 6'b000010}: return 8'h52;
            {3'd3, 6'b000000}: return 8'h53;
            {3'd1, 6'b000001}: return 8'h54;
            {3'd3, 6'b000100}: return 8'h55;
            {3'd4, 6'b001000}: return 8'h56;
            {3'd3, 6'b000110}: return 8'h57;
            {3'd4, 6'b001001}: return 8'h58;
            {3'd4, 6'b001101}: return 8'h59;
            {3'd4, 6'b000011}: return 8'h5A;
            default:           return 8'h3F;
        endcase
    endfunction
`endif

    // Classify the finishing mark and decide whether this edge ends a letter.
    always_comb begin
        run_inc = (run == {CNT_W{1'b1}}) ? run : run + RUN_ONE;
        sreg_nx = sreg;
        cnt_nx  = cnt;
        flag_nx = flag;
        if (run > DASH_LIM || cnt == SYM_LIM)
            flag_nx = 1'b1;
        if (cnt != SYM_LIM) begin
            sreg_nx[cnt] = (run > DOT_LIM);
            cnt_nx       = cnt + 3'd1;
        end
        do_emit = 1'b0;
        em_sreg = sreg;
        em_cnt  = cnt;
        em_flag = flag;
        case (state)
            MARK: begin
                do_emit = !w && (GAP_LIM <= RUN_ONE);
                em_sreg = sreg_nx;
                em_cnt  = cnt_nx;
                em_flag = flag_nx;
            end
            SPACE: do_emit = !w && (run_inc >= GAP_LIM);
            default: do_emit = 1'b0;
        endcase
    end

    // Letter FSM with registered emit outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            run   <= '0;
            cnt   <= '0;
            sreg  <= '0;
            flag  <= 1'b0;
            code  <= '0;
            len   <= '0;
            valid <= 1'b0;
            is_b  <= 1'b0;
            err   <= 1'b0;
`ifdef MORSE_ASCII_EN
            ascii <= 8'h00;
`endif
        end else begin
            valid <= 1'b0;
            if (do_emit) begin
                valid <= 1'b1;
                err   <= em_flag;
                if (em_flag) begin
                    code <= '0;
                    len  <= '0;
                    is_b <= 1'b0;
                end else begin
                    code <= em_sreg;
                    len  <= em_cnt;
                    is_b <= (em_cnt == 3'd4) && (em_sreg == B_CODE);
                end
`ifdef MORSE_ASCII_EN
                ascii <= em_flag ? 8'h3F : lookup({em_cnt, 6'(em_sreg)});
`endif
            end
            case (state)
                IDLE: begin
                    if (w) begin
                        state <= MARK;
                        run   <= RUN_ONE;
                    end
                end
                MARK: begin
                    if (w) begin
                        run <= run_inc;
                    end else if (do_emit) begin
                        state <= IDLE;
                        run   <= '0;
                        cnt   <= '0;
                        sreg  <= '0;
                        flag  <= 1'b0;
                    end else begin
                        state <= SPACE;
                        run   <= RUN_ONE;
                        cnt   <= cnt_nx;
                        sreg  <= sreg_nx;
                        flag  <= flag_nx;
                    end
                end
                SPACE: begin
                    if (w) begin
                        state <= MARK;
                        run   <= RUN_ONE;
                    end else if (do_emit) begin
                        state <= IDLE;
                        run   <= '0;
                        cnt   <= '0;
                        sreg  <= '0;
                        flag  <= 1'b0;
                    end else begin
                        run <= run_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef MORSE_ASCII_EN
    assign ascii = 8'h00;
`endif

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder: directed letters, expected results
// queued at stimulus time and checked by a monitor on each valid strobe.
module tb_morse_decoder;

    logic       clk;
    logic       rst_n;
    logic       w;
    logic [5:0] code;
    logic [2:0] len;
    logic       valid;
    logic       is_b;
    logic       err;
    logic [7:0] ascii;

    typedef struct {
        logic [5:0] code;
        logic [2:0] len;
        logic       is_b;
        logic       err;
        logic [7:0] ascii;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    morse_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .w     (w),
        .code  (code),
        .len   (len),
        .valid (valid),
        .is_b  (is_b),
        .err   (err),
        .ascii (ascii)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ea(input logic [7:0] a);
`ifdef MORSE_ASCII_EN
        return a;
`else
        return 8'h00;
`endif
    endfunction

    function automatic void chk(input string name,
                                input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, req, cyc);
        end
    endfunction

    // Monitor: pop one expectation per valid strobe.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'(valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("latency", 32'(cyc), 32'(e.cyc));
                chk("code", 32'(code), 32'(e.code));
                chk("len", 32'(len), 32'(e.len));
                chk("is_b", 32'(is_b), 32'(e.is_b));
                chk("err", 32'(err), 32'(e.err));
                chk("ascii", 32'(ascii), 32'(e.ascii));
            end
        end
    end

    task automatic drive(input logic [31:0] pat, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            w = pat[i];
            @(posedge clk);
            #1;
        end
        w = 1'b0;
    endtask

    task automatic letter(input logic [31:0] pat, input int n,
                          input logic [5:0] c, input logic [2:0] l,
                          input logic b, input logic e,
                          input logic [7:0] a);
        exp_t x;
        x.code  = c;
        x.len   = l;
        x.is_b  = b;
        x.err   = e;
        x.ascii = ea(a);
        x.cyc   = cyc + n;
        q.push_back(x);
        drive(pat, n);
    endtask

    task automatic chk_zero(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_code"}, 32'(code), 32'd0);
        chk({tag, "_len"}, 32'(len), 32'd0);
        chk({tag, "_is_b"}, 32'(is_b), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_ascii"}, 32'(ascii), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        w = 1'b0;
        repeat (3) @(posedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // B: -...
        letter(32'b111010101000, 12, 6'b000001, 3'd4, 1'b1, 1'b0, 8'h42);
        // E then T back-to-back
        letter(32'b1000, 4, 6'b000000, 3'd1, 1'b0, 1'b0, 8'h45);
        letter(32'b111000, 6, 6'b000001, 3'd1, 1'b0, 1'b0, 8'h54);
        // outputs hold after the strobe
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("hold_valid", 32'(valid), 32'd0);
        chk("hold_code", 32'(code), 32'd1);
        chk("hold_len", 32'(len), 32'd1);
        @(posedge clk);
        #1;
        // seven dots: overflow
        letter(32'b1010101010101000, 16, 6'b0, 3'd0, 1'b0, 1'b1, 8'h3F);
        // eight-sample mark: too long
        letter(32'b11111111000, 11, 6'b0, 3'd0, 1'b0, 1'b1, 8'h3F);
        // reset mid-letter discards it
        drive(32'b11101, 5);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(32'b000, 3);
        chk_zero("midreset");
        @(posedge clk);
        #1;
        letter(32'b1000, 4, 6'b000000, 3'd1, 1'b0, 1'b0, 8'h45);
        // 2-sample dot, 3-sample dash: A
        letter(32'b110111000, 9, 6'b000010, 3'd2, 1'b0, 1'b0, 8'h41);

        for (int i = 0; i < 20 && q.size() != 0; i++)
            @(posedge clk);
        repeat (3) @(posedge clk);
        chk("pending_expected", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
